// File: rtl/down_counter_timer_pkg.sv
// Shared definitions for the down counter / countdown timer.
package timer_pkg;

    localparam int DEFAULT_WIDTH = 4;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/down_counter_timer_if.sv
// Control and status bundle of the down counter timer.
import timer_pkg::*;

interface down_counter_timer_if #(
    parameter int WIDTH = DEFAULT_WIDTH
);
    logic             load;
    logic [WIDTH-1:0] loadVal;
    logic             en;
    logic             autoReload;
    logic [WIDTH-1:0] q;
    logic             running;
    logic             done;
    logic             borrowOut;

    modport master (
        output load, loadVal, en, autoReload,
        input  q, running, done, borrowOut
    );

    modport slave (
        input  load, loadVal, en, autoReload,
        output q, running, done, borrowOut
    );
endinterface

// File: rtl/down_counter_timer.sv
// Loadable down counter with terminal-count done pulse and optional auto-reload.
//
//   state   | meaning
//   --------+---------------------------------------------------------
//   ST_IDLE | stopped; q holds (0 after reset/expiry), en ignored
//   ST_RUN  | counting down on enabled cycles toward terminal count 1
import timer_pkg::*;

module down_counter_timer #(
    parameter int WIDTH = DEFAULT_WIDTH
) (
    input  logic                  clk,
    input  logic                  reset,
    down_counter_timer_if.slave   bus
);

    state_e           state_q, state_n;
    logic [WIDTH-1:0] q_q, q_n;
    logic [WIDTH-1:0] reload_q, reload_n;
    logic             done_q, done_n;
    logic             terminal;

    assign terminal = (q_q == WIDTH'(1));

    // State, count, reload value and done pulse registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            q_q      <= '0;
            reload_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_n;
            q_q      <= q_n;
            reload_q <= reload_n;
            done_q   <= done_n;
        end
    end

    // Next state: load beats counting; terminal count raises done for one cycle.
    always_comb begin
        state_n  = state_q;
        q_n      = q_q;
        reload_n = reload_q;
        done_n   = 1'b0;
        if (bus.load) begin
            q_n      = bus.loadVal;
            reload_n = bus.loadVal;
            state_n  = (bus.loadVal != '0) ? ST_RUN : ST_IDLE;
        end else if (state_q == ST_RUN && bus.en) begin
            if (terminal) begin
                done_n = 1'b1;
                if (bus.autoReload) begin
                    q_n = reload_q;
                end else begin
                    q_n     = '0;
                    state_n = ST_IDLE;
                end
            end else if (q_q != '0) begin
                // q==0 cannot occur in RUN; the guard keeps q from wrapping.
                q_n = q_q - WIDTH'(1);
            end
        end
    end

    // Status outputs; borrowOut strobes the next stage of a cascade.
    assign bus.q         = q_q;
    assign bus.done      = done_q;
    assign bus.running   = (state_q == ST_RUN);
    assign bus.borrowOut = (state_q == ST_RUN) && bus.en && terminal;

endmodule

// File: tb/tb_down_counter_timer.sv
// Directed and random stimulus for down_counter_timer with a scoreboard queue.
module tb_down_counter_timer;

    localparam int W = 4;

    typedef struct {
        logic [W-1:0] q;
        logic         run;
        logic         done;
    } exp_t;

    logic clk;
    logic reset;
    down_counter_timer_if #(.WIDTH(W)) bus ();

    down_counter_timer #(.WIDTH(W)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];

    // reference model state
    int   m_q   = 0;
    int   m_rel = 0;
    bit   m_run = 0;
    bit   m_done = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check borrowOut, advance model, compare after edge.
    task automatic step(input bit rst, input bit ld, input int val, input bit e, input bit ar);
        exp_t x;
        bit   exp_borrow;
        @(negedge clk);
        reset         = rst;
        bus.load      = ld;
        bus.loadVal   = W'(val);
        bus.en        = e;
        bus.autoReload = ar;
        #1;
        exp_borrow = m_run && e && (m_q == 1);
        check("borrowOut", bus.borrowOut, exp_borrow);
        if (rst) begin
            m_q = 0; m_rel = 0; m_run = 0; m_done = 0;
        end else if (ld) begin
            m_q = val; m_rel = val; m_run = (val != 0); m_done = 0;
        end else if (m_run && e) begin
            if (m_q == 1) begin
                m_done = 1;
                if (ar) m_q = m_rel;
                else begin m_q = 0; m_run = 0; end
            end else begin
                m_q = m_q - 1;
                m_done = 0;
            end
        end else begin
            m_done = 0;
        end
        x.q = W'(m_q); x.run = m_run; x.done = m_done;
        sb.push_back(x);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            check("sb_empty", 1, 0);
        end else begin
            x = sb.pop_front();
            check("q", bus.q, x.q);
            check("running", bus.running, x.run);
            check("done", bus.done, x.done);
        end
    endtask

    int seq2[6] = '{5, 4, 3, 2, 1, 0};
    int dn2[6]  = '{0, 0, 0, 0, 0, 1};
    int seq3[9] = '{3, 2, 1, 3, 2, 1, 3, 2, 1};
    int dn3[9]  = '{0, 0, 0, 1, 0, 0, 1, 0, 0};
    int done_cnt;

    initial begin
        reset = 1'b1; bus.load = 1'b0; bus.loadVal = '0; bus.en = 1'b0; bus.autoReload = 1'b0;

        // 1: reset two cycles with en high, then en in IDLE does nothing
        step(1, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("t1_q_reset", bus.q, 0);
        check("t1_run_reset", bus.running, 0);
        check("t1_done_reset", bus.done, 0);
        step(0, 0, 0, 1, 0);
        check("t1_idle_en", bus.q, 0);

        // 2: load 5, one-shot
        step(0, 1, 5, 1, 0);
        check("t2_q", bus.q, seq2[0]);
        for (int i = 1; i < 6; i++) begin
            step(0, 0, 0, 1, 0);
            check("t2_q", bus.q, seq2[i]);
            check("t2_done", bus.done, dn2[i]);
        end
        check("t2_run_drop", bus.running, 0);
        step(0, 0, 0, 1, 0);
        check("t2_q_hold0", bus.q, 0);
        check("t2_done_once", bus.done, 0);

        // 3: load 3, auto-reload, 9 cycles
        step(0, 1, 3, 1, 1);
        check("t3_q", bus.q, seq3[0]);
        for (int i = 1; i < 9; i++) begin
            step(0, 0, 0, 1, 1);
            check("t3_q", bus.q, seq3[i]);
            check("t3_done", bus.done, dn3[i]);
        end

        // 4: load 4, en toggled
        step(0, 1, 4, 0, 0);
        for (int i = 0; i < 8; i++) step(0, 0, 0, (i % 2) == 0, 0);
        check("t4_q_mid", bus.q, 0);
        step(0, 1, 4, 0, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 0, 0);
        check("t4_q_hold", bus.q, 3);

        // 5: load 6, two counts, reload 2; load wins over terminal count
        step(0, 1, 6, 1, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("t5_q_after2", bus.q, 4);
        step(0, 1, 2, 1, 0);
        step(0, 0, 0, 1, 0);
        check("t5_q1", bus.q, 1);
        step(0, 1, 2, 1, 0);
        check("t5_load_wins_q", bus.q, 2);
        check("t5_load_wins_done", bus.done, 0);
        step(0, 0, 0, 1, 0);
        step(0, 0, 0, 1, 0);
        check("t5_q0", bus.q, 0);
        check("t5_done", bus.done, 1);

        // 6: load 0, then reset at terminal count suppresses done
        step(0, 1, 0, 1, 1);
        check("t6_load0_run", bus.running, 0);
        check("t6_load0_q", bus.q, 0);
        step(0, 1, 2, 1, 0);
        step(0, 0, 0, 1, 0);
        step(1, 0, 0, 1, 0);
        check("t6_rst_q", bus.q, 0);
        check("t6_rst_done", bus.done, 0);
        step(0, 0, 0, 1, 0);
        check("t6_rst_done_next", bus.done, 0);

        // max period with auto-reload; N=1 pulses every cycle
        step(0, 1, 15, 1, 1);
        done_cnt = 0;
        for (int i = 0; i < 30; i++) begin
            step(0, 0, 0, 1, 1);
            if (bus.done) done_cnt++;
        end
        check("max_period_pulses", done_cnt, 2);
        step(0, 1, 1, 1, 1);
        step(0, 0, 0, 1, 1);
        step(0, 0, 0, 1, 1);
        check("n1_done", bus.done, 1);
        check("n1_q", bus.q, 1);
        // clearing autoReload mid-run stops at the next terminal count
        step(0, 0, 0, 1, 0);
        check("ar_off_q", bus.q, 0);
        check("ar_off_run", bus.running, 0);

        // random mix
        for (int i = 0; i < 200; i++) begin
            step(($urandom_range(0, 40) == 0), ($urandom_range(0, 9) == 0),
                 $urandom_range(0, 15), $urandom_range(0, 3) != 0, $urandom_range(0, 1));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
